me_search_ctrl: RTL and testbench

Search-window scheduler for the 4x4 SAD systolic datapath in the motion-estimation path. On `start` it streams search-range column reads into the datapath row by row, tags each issued read with its candidate position, and realigns the tags with the SAD result after the fixed datapath latency. It keeps a running minimum and reports the best SAD and its signed motion vector with a one-cycle `done` pulse.

---
 rtl/me_pkg.sv | 31 +++
 rtl/me_search_ctrl_if.sv | 25 ++
 rtl/me_tag_delay.sv | 32 +++
 rtl/me_search_ctrl.sv | 119 +++++++++++
 tb/tb_me_search_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// Shared types and widths for the motion-estimation search-window scheduler.
// Tag field widths are sized for the default 16x16 candidate window.
package me_pkg;

   localparam int SAD_W  = 12;
   localparam int BLK    = 4;
   localparam int TAG_XW = 5;
   localparam int TAG_YW = 4;
   localparam int ADDR_W = TAG_YW + TAG_XW;
   localparam int MV_W   = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } me_state_t;

   typedef struct packed {
      logic              v;
      logic [TAG_XW-1:0] pos_x;
      logic [TAG_YW-1:0] pos_y;
   } me_tag_t;

   // Candidate position to signed motion vector, centred on the window.
   function automatic logic signed [MV_W-1:0] pos_to_mv(input logic [TAG_XW-1:0] pos,
                                                        input logic [TAG_XW-1:0] half);
      return $signed(MV_W'(pos) - MV_W'(half));
   endfunction

endpackage

// File: rtl/me_search_ctrl_if.sv
// Control/datapath bundle between the search scheduler and its host plus SAD datapath.
interface me_search_ctrl_if;
   import me_pkg::*;

   logic                    start;
   logic                    busy;
   logic                    done;
   logic                    sr_rd_en;
   logic [ADDR_W-1:0]       sr_addr;
   logic [SAD_W-1:0]        sad_in;
   logic [SAD_W-1:0]        best_sad;
   logic signed [MV_W-1:0]  best_mv_x;
   logic signed [MV_W-1:0]  best_mv_y;

   modport master (
      output start, sad_in,
      input  busy, done, sr_rd_en, sr_addr, best_sad, best_mv_x, best_mv_y
   );

   modport slave (
      input  start, sad_in,
      output busy, done, sr_rd_en, sr_addr, best_sad, best_mv_x, best_mv_y
   );

endinterface

// File: rtl/me_tag_delay.sv
// Fixed-latency delay line that carries candidate tags alongside the SAD datapath.
module me_tag_delay
   import me_pkg::*;
#(
   parameter int DEPTH = 7
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    clr,
   input  me_tag_t tag_in,
   output me_tag_t tag_out
);

   me_tag_t [DEPTH-1:0] stage;

   // NOTE: every stage is reset, not just the head, because a stale v=1 left in the line would trigger a phantom compare after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage <= '0;
      end else if (clr) begin
         stage <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/me_search_ctrl.sv
// Search-window scheduler: issues column reads row by row, realigns candidate tags
// with the SAD datapath output and tracks the running minimum and its motion vector.
module me_search_ctrl
   import me_pkg::*;
#(
   parameter int N_POS_X  = 16,
   parameter int N_POS_Y  = 16,
   parameter int PIPE_LAT = 7
) (
   input  logic            clk,
   input  logic            rst,
   me_search_ctrl_if.slave bus
);

   localparam int COLS = N_POS_X + BLK - 1;
   localparam int CW   = $clog2(COLS);
   localparam int RW   = $clog2(N_POS_Y);
   localparam int DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   me_state_t              state, state_nxt;
   logic [CW-1:0]          col;
   logic [RW-1:0]          row;
   logic [DW-1:0]          drain_cnt;
   logic                   last_col, last_row, drain_end, accept;
   me_tag_t                tag_in, tag_out;
   logic [SAD_W-1:0]       best_sad;
   logic signed [MV_W-1:0] best_mv_x, best_mv_y;

   assign last_col  = (col == CW'(COLS - 1));
   assign last_row  = (row == RW'(N_POS_Y - 1));
   assign drain_end = (drain_cnt == DW'(PIPE_LAT - 1));
   assign accept    = (state == ST_IDLE) && bus.start;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the default comes first so no path through the case can leave state_nxt unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bus.start)           state_nxt = ST_FEED;
         ST_FEED:  if (last_col && last_row) state_nxt = ST_DRAIN;
         ST_DRAIN: if (drain_end)           state_nxt = ST_DONE;
         ST_DONE:                           state_nxt = ST_IDLE;
         default:                           state_nxt = ST_IDLE;
      endcase
   end

   assign bus.busy     = (state == ST_FEED) || (state == ST_DRAIN);
   assign bus.done     = (state == ST_DONE);
   assign bus.sr_rd_en = (state == ST_FEED);
   assign bus.sr_addr  = ADDR_W'({row, col});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         drain_cnt <= '0;
      end else begin
         drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
         if (state == ST_FEED) begin
            if (last_col) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end else if (state == ST_IDLE) begin
            col <= '0;
            row <= '0;
         end
      end
   end

   // The first BLK-1 columns of each row only prime the systolic array.
   always_comb begin
      tag_in = '0;
      if (state == ST_FEED) begin
         tag_in.v     = (col >= CW'(BLK - 1));
         tag_in.pos_x = TAG_XW'(col - CW'(BLK - 1));
         tag_in.pos_y = TAG_YW'(row);
      end
   end

   me_tag_delay #(
      .DEPTH (PIPE_LAT)
   ) u_tag_delay (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == ST_IDLE),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // Strict less-than keeps the earliest raster position on ties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_sad  <= '1;
         best_mv_x <= '0;
         best_mv_y <= '0;
      end else if (accept) begin
         best_sad  <= '1;
         best_mv_x <= '0;
         best_mv_y <= '0;
      end else if (tag_out.v && (bus.sad_in < best_sad)) begin
         best_sad  <= bus.sad_in;
         best_mv_x <= pos_to_mv(tag_out.pos_x, TAG_XW'(N_POS_X / 2));
         best_mv_y <= pos_to_mv(TAG_XW'(tag_out.pos_y), TAG_XW'(N_POS_Y / 2));
      end
   end

   assign bus.best_sad  = best_sad;
   assign bus.best_mv_x = best_mv_x;
   assign bus.best_mv_y = best_mv_y;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Self-checking bench: models the SAD datapath from a per-position SAD map and
// compares the scheduler's results against a raster-order minimum search.
module tb_me_search_ctrl;
   import me_pkg::*;

   localparam int NX      = 16;
   localparam int NY      = 16;
   localparam int LAT     = 7;
   localparam int NCOL    = NX + BLK - 1;
   localparam int F       = NY * NCOL;
   localparam int DONE_AT = F + LAT + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   me_search_ctrl_if bus ();

   me_search_ctrl #(
      .N_POS_X  (NX),
      .N_POS_Y  (NY),
      .PIPE_LAT (LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_vec      = 0;
   int n_err      = 0;
   int cyc        = 0;
   int done_total = 0;
   bit fill_zero  = 1'b0;
   int sad_map [NY][NX];
   int addr_log [$];
   logic              hist_en   [LAT+1] = '{default: 1'b0};
   logic [ADDR_W-1:0] hist_addr [LAT+1] = '{default: '0};

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Value the datapath returns for a slot: map entry for a real candidate, filler otherwise.
   function automatic logic [SAD_W-1:0] slot_val(input logic en, input logic [ADDR_W-1:0] a);
      int c, r;
      c = int'(a[4:0]);
      r = int'(a[8:5]);
      if (en && c >= BLK - 1 && c - (BLK - 1) < NX && r < NY)
         return SAD_W'(sad_map[r][c-(BLK-1)]);
      if (fill_zero) return '0;
      return SAD_W'($urandom_range(0, 4095));
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      for (int i = LAT; i > 0; i--) begin
         hist_en[i]   = hist_en[i-1];
         hist_addr[i] = hist_addr[i-1];
      end
      hist_en[0]   = bus.sr_rd_en;
      hist_addr[0] = bus.sr_addr;
      if (bus.sr_rd_en) addr_log.push_back(int'(bus.sr_addr));
      if (bus.done) done_total++;
      bus.sad_in = slot_val(hist_en[LAT], hist_addr[LAT]);
   end

   task automatic fill_map(input int v);
      for (int y = 0; y < NY; y++)
         for (int x = 0; x < NX; x++)
            sad_map[y][x] = v;
   endtask

   task automatic rand_map(input int hi);
      for (int y = 0; y < NY; y++)
         for (int x = 0; x < NX; x++)
            sad_map[y][x] = int'($urandom_range(0, hi));
   endtask

   // Minimum over candidates in raster order; the first strict minimum wins.
   task automatic model_best(output int b, output int mx, output int my);
      b = 4095; mx = 0; my = 0;
      for (int y = 0; y < NY; y++)
         for (int x = 0; x < NX; x++)
            if (sad_map[y][x] < b) begin
               b  = sad_map[y][x];
               mx = x - NX / 2;
               my = y - NY / 2;
            end
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_busy"},     int'(bus.busy), 0);
      check({pfx, "_done"},     int'(bus.done), 0);
      check({pfx, "_rd_en"},    int'(bus.sr_rd_en), 0);
      check({pfx, "_addr"},     int'(bus.sr_addr), 0);
      check({pfx, "_best_sad"}, int'(bus.best_sad), 4095);
      check({pfx, "_mv_x"},     int'(bus.best_mv_x), 0);
      check({pfx, "_mv_y"},     int'(bus.best_mv_y), 0);
   endtask

   // Start a search; optionally pulse start or assert reset at a given cycle.
   task automatic run_search(input int pulse_at, input int rst_at, output int done_rel);
      int  s;
      int  rel;
      bit  seen;
      seen     = 1'b0;
      done_rel = -1;
      @(negedge clk); #1;
      addr_log.delete();
      bus.start = 1'b1;
      s = cyc;
      @(negedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 2 * DONE_AT && !seen; k++) begin
         rel = cyc - s;
         if (bus.done) begin
            seen     = 1'b1;
            done_rel = rel;
            check("busy_in_done", int'(bus.busy), 0);
         end else begin
            bus.start = (rel == pulse_at);
            if (rel == rst_at) begin
               bus.start = 1'b0;
               rst = 1'b1;
               #1;
               check_reset_vals("mid_rst");
               @(negedge clk); #1;
               rst = 1'b0;
               return;
            end
            @(negedge clk); #1;
         end
      end
      bus.start = 1'b0;
      check("done_seen", int'(seen), 1);
      if (seen) begin
         @(negedge clk); #1;
         check("done_width", int'(bus.done), 0);
      end
   endtask

   task automatic run_random(input string tag, input int hi);
      int d, b, mx, my;
      rand_map(hi);
      run_search(-1, -1, d);
      model_best(b, mx, my);
      check({tag, "_done_cyc"}, d, DONE_AT);
      check({tag, "_sad"},  int'(bus.best_sad), b);
      check({tag, "_mv_x"}, int'(bus.best_mv_x), mx);
      check({tag, "_mv_y"}, int'(bus.best_mv_y), my);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, base, b, mx, my;
      bus.start = 1'b0;
      rst       = 1'b1;

      // Reset and idle
      repeat (10) @(negedge clk);
      #1;
      check_reset_vals("rst");
      rst = 1'b0;
      addr_log.delete();
      repeat (20) @(negedge clk);
      #1;
      check("idle_no_rd", addr_log.size(), 0);
      check("idle_no_done", done_total, 0);

      // Single minimum and address order
      fill_map(100);
      sad_map[9][5] = 20;
      run_search(-1, -1, d);
      check("t2_done_cyc", d, DONE_AT);
      check("t2_sad",  int'(bus.best_sad), 20);
      check("t2_mv_x", int'(bus.best_mv_x), -3);
      check("t2_mv_y", int'(bus.best_mv_y), 1);
      check("t2_addr_count", addr_log.size(), F);
      for (int i = 0; i < addr_log.size() && i < F; i++)
         check($sformatf("t2_addr[%0d]", i), addr_log[i], (i / NCOL) * 32 + (i % NCOL));
      repeat (5) @(negedge clk);
      #1;
      check("t2_hold_sad", int'(bus.best_sad), 20);

      // Tie keeps earlier raster position
      fill_map(90);
      sad_map[3][2]  = 50;
      sad_map[3][10] = 50;
      run_search(-1, -1, d);
      check("t3_sad",  int'(bus.best_sad), 50);
      check("t3_mv_x", int'(bus.best_mv_x), -6);
      check("t3_mv_y", int'(bus.best_mv_y), -5);

      // Fill slots carry zero SAD but must be ignored
      fill_zero = 1'b1;
      fill_map(200);
      sad_map[0][0] = 150;
      run_search(-1, -1, d);
      check("t4_sad",  int'(bus.best_sad), 150);
      check("t4_mv_x", int'(bus.best_mv_x), -8);
      check("t4_mv_y", int'(bus.best_mv_y), -8);
      fill_zero = 1'b0;

      // start while busy is ignored
      rand_map(4095);
      base = done_total;
      run_search(50, -1, d);
      model_best(b, mx, my);
      check("t5_done_cyc", d, DONE_AT);
      repeat (DONE_AT + 20) @(negedge clk);
      #1;
      check("t5_one_done", done_total - base, 1);
      check("t5_sad", int'(bus.best_sad), b);
      check("t5_mv_x", int'(bus.best_mv_x), mx);
      check("t5_mv_y", int'(bus.best_mv_y), my);

      // Reset mid-search, then a clean search
      rand_map(4095);
      base = done_total;
      run_search(-1, 100, d);
      repeat (DONE_AT + 20) @(negedge clk);
      #1;
      check("t6_no_done", done_total - base, 0);
      check("t6_idle_busy", int'(bus.busy), 0);
      check("t6_idle_sad", int'(bus.best_sad), 4095);
      run_random("t6_after", 4095);

      // Randomised searches, one with a narrow range to provoke ties
      run_random("rnd0", 4095);
      run_random("rnd1", 4095);
      run_random("rnd_tie", 7);
      run_random("rnd_back", 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
